// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for a single-cycle MIPS core.
//
// The unit owns the program counter and reads instruction words from memory over a
// req/ack handshake that can have any latency. Each {pc, instruction} pair that comes
// back goes into a small prefetch FIFO. The core takes entries from that FIFO over a
// valid/ready handshake. A taken branch or a jump on the consumed instruction flushes
// the FIFO and restarts fetch at the target address.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   imem_req / imem_addr       registered word-read request (held until acked)
//   imem_ack / imem_rdata      request accepted, read data valid in the same cycle
//   instr_valid / instr_ready  FIFO head handshake towards the core
//   instr_out / instr_pc       head instruction and its byte address
//   pc_plus4                   instr_pc + 4 (wraps)
//   branch_taken / branch_imm  taken branch on the consumed instruction, word offset
//   jump / jump_index          jump on the consumed instruction, word index
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned         FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  // Instruction memory
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  // Core side
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic [PC_WIDTH-1:0]    pc_plus4,
  // Redirect from the consumed instruction
  input  logic                   branch_taken,
  input  logic [15:0]            branch_imm,
  input  logic                   jump,
  input  logic [25:0]            jump_index
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    StIdle,  // no request outstanding
    StWait   // imem_req high, waiting for imem_ack
  } fetch_state_e;

  fetch_state_e state_q, state_d;

  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                discard_q, discard_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;

  // Prefetch storage. It is not reset because only occupied slots are ever read.
  logic [INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem   [FIFO_DEPTH];

  // The last head value is kept so the outputs hold steady while the FIFO is empty.
  logic [INSTR_WIDTH-1:0] hold_instr_q;
  logic [PC_WIDTH-1:0]    hold_pc_q;

  logic                   fifo_nonempty;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic [PC_WIDTH-1:0]    head_pc;
  logic                   consume;
  logic                   redirect;
  logic                   acked;
  logic                   push;
  logic                   still_waiting;
  logic [PC_WIDTH-1:0]    jump_target;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    redirect_target;
  logic signed [33:0]     branch_off;

  // ---------------------------------------------------------------------------
  // Head of FIFO and core handshake
  // ---------------------------------------------------------------------------
  assign fifo_nonempty = (count_q != '0);
  assign head_instr    = fifo_nonempty ? data_mem[rd_ptr_q] : hold_instr_q;
  assign head_pc       = fifo_nonempty ? pc_mem[rd_ptr_q]   : hold_pc_q;

  assign instr_valid = fifo_nonempty;
  assign instr_out   = head_instr;
  assign instr_pc    = head_pc;
  assign pc_plus4    = head_pc + PC_WIDTH'(4);

  assign consume  = instr_valid & instr_ready;
  // Branch and jump inputs only count on a consume cycle.
  assign redirect = consume & (jump | branch_taken);

  // ---------------------------------------------------------------------------
  // Redirect targets
  // ---------------------------------------------------------------------------
  assign jump_target   = PC_WIDTH'({jump_index, 2'b00});
  assign branch_off    = {{16{branch_imm[15]}}, branch_imm, 2'b00};
  assign branch_target = pc_plus4 + PC_WIDTH'(branch_off);
  // If both are set, the jump target is used.
  assign redirect_target = jump ? jump_target : branch_target;

  // ---------------------------------------------------------------------------
  // Memory handshake qualifiers
  // ---------------------------------------------------------------------------
  assign acked = (state_q == StWait) & imem_ack;
  // Data is stale if it answers a request issued before a redirect, or if it
  // arrives in the same cycle as a redirect.
  assign push  = acked & ~discard_q & ~redirect;
  assign still_waiting = (state_q == StWait) & ~imem_ack;

  assign imem_req  = (state_q == StWait);
  assign imem_addr = addr_q;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      // Flush the FIFO by dropping every entry.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (consume) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, consume})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PC, discard flag and fetch FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    state_d    = state_q;
    addr_d     = addr_q;

    if (redirect) begin
      fetch_pc_d = redirect_target;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
    end

    if (redirect) begin
      // An unanswered request now targets the wrong path, so mark its reply as stale.
      discard_d = still_waiting;
    end else if (acked && discard_q) begin
      discard_d = 1'b0;
    end

    // At most one request is outstanding. A new request starts only when none
    // remains and the FIFO will have room after this edge.
    unique case (state_q)
      StWait: begin
        if (still_waiting) begin
          state_d = StWait;
          addr_d  = addr_q;
        end else if (count_d < DepthCnt) begin
          state_d = StWait;
          addr_d  = fetch_pc_d;
        end else begin
          state_d = StIdle;
          addr_d  = fetch_pc_d;
        end
      end
      default: begin
        if (count_d < DepthCnt) begin
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
        addr_d = fetch_pc_d;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      discard_q    <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (fifo_nonempty) begin
        hold_instr_q <= head_instr;
        hold_pc_q    <= head_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

endmodule
